simple_ctrl_fsm: RTL and testbench

SIMPLE_CTRL_FSM -- requirements
Module: simple_ctrl_fsm

---
 rtl/simple_isa_pkg.sv | 68 ++++++
 rtl/simple_decoder.sv | 80 ++++++++
 rtl/simple_ctrl_fsm.sv | 114 +++++++++++
 tb/tb_simple_ctrl_fsm.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_isa_pkg.sv
// ============================================================================
//  Module      : simple_isa_pkg
//  Description : ISA constants, opcode/phase/state enums and control bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package simple_isa_pkg;

    localparam int c_INSTR_W = 16;
    localparam int c_OP_W    = 4;
    localparam int c_REG_AW  = 2;
    localparam int c_IMM_W   = 8;
    localparam int c_ALU_W   = 3;

    localparam logic [c_ALU_W-1:0] c_ALU_ADD  = 3'd0;
    localparam logic [c_ALU_W-1:0] c_ALU_SUB  = 3'd1;
    localparam logic [c_ALU_W-1:0] c_ALU_AND  = 3'd2;
    localparam logic [c_ALU_W-1:0] c_ALU_OR   = 3'd3;
    localparam logic [c_ALU_W-1:0] c_ALU_PASS = 3'd7;

    typedef enum logic [c_OP_W-1:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_ADDI = 4'h5,
        OP_LD   = 4'h6,
        OP_ST   = 4'h7,
        OP_BEQZ = 4'h8,
        OP_JMP  = 4'h9,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        PH_IF = 2'd0,
        PH_ID = 2'd1,
        PH_EX = 2'd2,
        PH_WB = 2'd3
    } phase_e;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    typedef struct packed {
        logic [c_REG_AW-1:0] rf_raddr_a;
        logic [c_REG_AW-1:0] rf_raddr_b;
        logic [c_REG_AW-1:0] rf_waddr;
        logic                rf_we;
        logic [c_ALU_W-1:0]  alu_op;
        logic                alu_src_imm;
        logic [c_IMM_W-1:0]  imm;
        logic                dmem_re;
        logic                dmem_we;
        logic                wb_sel;
        logic                upd_z;
        logic                is_jmp;
        logic                is_beqz;
        logic                is_halt;
        logic                is_illegal;
    } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/simple_decoder.sv
// ============================================================================
//  Module      : simple_decoder
//  Description : Combinational decode of IR and phase into the control bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module simple_decoder
    import simple_isa_pkg::*;
(
    input  logic [c_INSTR_W-1:0] i_ir,
    input  logic [1:0]           i_phase,
    output ctrl_t                o_ctrl
);

    logic [c_OP_W-1:0]   w_opc;
    logic [c_REG_AW-1:0] w_rd;
    logic [c_REG_AW-1:0] w_rs;
    logic [c_ALU_W-1:0]  w_alu_op;
    logic                w_alu;
    logic                w_src_imm;
    logic                w_ld;
    logic                w_st;

    assign w_opc = i_ir[15:12];
    assign w_rd  = i_ir[11:10];
    assign w_rs  = i_ir[9:8];

    always_comb begin
        o_ctrl    = '0;
        w_alu_op  = c_ALU_ADD;
        w_alu     = 1'b0;
        w_src_imm = 1'b0;
        w_ld      = 1'b0;
        w_st      = 1'b0;

        case (w_opc)
            OP_NOP:  ;
            OP_ADD:  begin w_alu = 1'b1; w_alu_op = c_ALU_ADD; end
            OP_SUB:  begin w_alu = 1'b1; w_alu_op = c_ALU_SUB; end
            OP_AND:  begin w_alu = 1'b1; w_alu_op = c_ALU_AND; end
            OP_OR:   begin w_alu = 1'b1; w_alu_op = c_ALU_OR;  end
            OP_ADDI: begin w_alu = 1'b1; w_alu_op = c_ALU_ADD;  w_src_imm = 1'b1; end
            OP_LD:   begin w_ld  = 1'b1; w_alu_op = c_ALU_PASS; w_src_imm = 1'b1; end
            OP_ST:   begin w_st  = 1'b1; w_alu_op = c_ALU_PASS; w_src_imm = 1'b1; end
            OP_BEQZ: o_ctrl.is_beqz = 1'b1;
            OP_JMP:  o_ctrl.is_jmp  = 1'b1;
            OP_HALT: o_ctrl.is_halt = 1'b1;
            default: o_ctrl.is_illegal = 1'b1;
        endcase

        o_ctrl.imm   = i_ir[7:0];
        o_ctrl.upd_z = w_alu;

        if (i_phase != PH_IF) begin
            o_ctrl.rf_raddr_a = w_rd;
            o_ctrl.rf_raddr_b = w_rs;
        end

        if (i_phase == PH_EX) begin
            o_ctrl.alu_op      = w_alu_op;
            o_ctrl.alu_src_imm = w_src_imm;
            o_ctrl.dmem_we     = w_st;
        end

        // Load keeps the read strobe up through WB so the data can be written back.
        o_ctrl.dmem_re = w_ld && ((i_phase == PH_EX) || (i_phase == PH_WB));

        if (i_phase == PH_WB) begin
            o_ctrl.rf_we  = w_alu || w_ld;
            o_ctrl.wb_sel = w_ld;
            if (w_alu || w_ld) begin
                o_ctrl.rf_waddr = w_rd;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/simple_ctrl_fsm.sv
// ============================================================================
//  Module      : simple_ctrl_fsm
//  Description : Four-phase control unit holding PC, IR, Z flag and run state.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module simple_ctrl_fsm
    import simple_isa_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [1:0]           phase,
    input  logic [c_INSTR_W-1:0] instr_rdata,
    input  logic                 alu_zero,
    output logic [PC_W-1:0]      imem_addr,
    output logic [c_REG_AW-1:0]  rf_raddr_a,
    output logic [c_REG_AW-1:0]  rf_raddr_b,
    output logic                 rf_we,
    output logic [c_REG_AW-1:0]  rf_waddr,
    output logic [c_ALU_W-1:0]   alu_op,
    output logic                 alu_src_imm,
    output logic [c_IMM_W-1:0]   imm,
    output logic                 dmem_re,
    output logic                 dmem_we,
    output logic                 wb_sel,
    output logic                 halted,
    output logic                 illegal
);

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [PC_W-1:0]        r_pc;
    logic [PC_W-1:0]        w_pc_nxt;
    logic [c_INSTR_W-1:0]   r_ir;
    logic                   r_z;
    logic                   r_illegal;
    logic                   w_run;
    ctrl_t                  w_ctrl;

    simple_decoder u_dec (
        .i_ir    (r_ir),
        .i_phase (phase),
        .o_ctrl  (w_ctrl)
    );

    assign w_run = (r_state == ST_RUN);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if ((r_state == ST_RUN) && (phase == PH_WB) && w_ctrl.is_halt) begin
            w_state_nxt = ST_HALTED;
        end
    end

    // Branch target is the 8-bit immediate fitted to the PC width.
    always_comb begin
        w_pc_nxt = r_pc + PC_W'(1);
        if (w_ctrl.is_jmp || (w_ctrl.is_beqz && r_z)) begin
            w_pc_nxt = PC_W'(w_ctrl.imm);
        end else if (w_ctrl.is_halt) begin
            w_pc_nxt = r_pc;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pc      <= '0;
            r_ir      <= '0;
            r_z       <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_run) begin
            if (phase == PH_IF) begin
                r_ir <= instr_rdata;
            end
            if ((phase == PH_ID) && w_ctrl.is_illegal) begin
                r_illegal <= 1'b1;
            end
            if ((phase == PH_EX) && w_ctrl.upd_z) begin
                r_z <= alu_zero;
            end
            if (phase == PH_WB) begin
                r_pc <= w_pc_nxt;
            end
        end
    end

    assign imem_addr   = r_pc;
    assign rf_raddr_a  = w_ctrl.rf_raddr_a;
    assign rf_raddr_b  = w_ctrl.rf_raddr_b;
    assign rf_waddr    = w_ctrl.rf_waddr;
    assign alu_op      = w_ctrl.alu_op;
    assign imm         = w_ctrl.imm;
    assign rf_we       = w_run && w_ctrl.rf_we;
    assign alu_src_imm = w_run && w_ctrl.alu_src_imm;
    assign dmem_re     = w_run && w_ctrl.dmem_re;
    assign dmem_we     = w_run && w_ctrl.dmem_we;
    assign wb_sel      = w_run && w_ctrl.wb_sel;
    assign halted      = !w_run;
    assign illegal     = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_simple_ctrl_fsm.sv
// ============================================================================
//  Module      : tb_simple_ctrl_fsm
//  Description : Randomised and directed self-checking bench for simple_ctrl_fsm.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_simple_ctrl_fsm;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  phase = 2'd0;
    logic        alu_zero = 1'b0;
    logic [15:0] instr_rdata;
    logic [7:0]  imem_addr;
    logic [1:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
    logic        rf_we, alu_src_imm, dmem_re, dmem_we, wb_sel, halted, illegal;
    logic [2:0]  alu_op;
    logic [7:0]  imm;

    logic [15:0] imem [256];

    int n_checks = 0;
    int n_errors = 0;
    int az_mode  = 2;

    // Reference state, advanced from the instruction-set rules only.
    int          m_pc;
    logic [15:0] m_ir;
    bit          m_z, m_halt, m_ill;

    assign instr_rdata = imem[imem_addr];

    always #5 clk = ~clk;

    simple_ctrl_fsm #(.PC_W(8)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .phase       (phase),
        .instr_rdata (instr_rdata),
        .alu_zero    (alu_zero),
        .imem_addr   (imem_addr),
        .rf_raddr_a  (rf_raddr_a),
        .rf_raddr_b  (rf_raddr_b),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .imm         (imm),
        .dmem_re     (dmem_re),
        .dmem_we     (dmem_we),
        .wb_sel      (wb_sel),
        .halted      (halted),
        .illegal     (illegal)
    );

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== 32'(exp)) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_alu(input int op);
        case (op)
            2:       return 1;
            3:       return 2;
            4:       return 3;
            6, 7:    return 7;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = 0; m_ir = 16'h0000; m_z = 0; m_halt = 0; m_ill = 0;
    endtask

    task automatic model_edge();
        int op;
        op = int'(m_ir[15:12]);
        if (!resetn || m_halt) return;
        case (int'(phase))
            0: m_ir = imem[m_pc];
            1: if (op >= 10 && op <= 14) m_ill = 1;
            2: if (op >= 1 && op <= 5) m_z = alu_zero;
            default: begin
                if (op == 9 || (op == 8 && m_z)) m_pc = int'(m_ir[7:0]);
                else if (op == 15)               m_halt = 1;
                else                             m_pc = (m_pc + 1) % 256;
            end
        endcase
    endtask

    task automatic check_all();
        int op, rd, rs, ph;
        bit run, wr;
        op  = int'(m_ir[15:12]);
        rd  = int'(m_ir[11:10]);
        rs  = int'(m_ir[9:8]);
        ph  = int'(phase);
        run = !m_halt;
        wr  = run && ph == 3 && op >= 1 && op <= 6;
        chk("imem_addr",   32'(imem_addr),   m_pc);
        chk("rf_raddr_a",  32'(rf_raddr_a),  (ph == 0) ? 0 : rd);
        chk("rf_raddr_b",  32'(rf_raddr_b),  (ph == 0) ? 0 : rs);
        chk("alu_op",      32'(alu_op),      (ph == 2) ? exp_alu(op) : 0);
        chk("alu_src_imm", 32'(alu_src_imm), (run && ph == 2 && op >= 5 && op <= 7) ? 1 : 0);
        chk("imm",         32'(imm),         int'(m_ir[7:0]));
        chk("dmem_re",     32'(dmem_re),     (run && op == 6 && ph >= 2) ? 1 : 0);
        chk("dmem_we",     32'(dmem_we),     (run && op == 7 && ph == 2) ? 1 : 0);
        chk("rf_we",       32'(rf_we),       wr ? 1 : 0);
        chk("rf_waddr",    32'(rf_waddr),    wr ? rd : 0);
        chk("wb_sel",      32'(wb_sel),      (run && op == 6 && ph == 3) ? 1 : 0);
        chk("halted",      32'(halted),      m_halt ? 1 : 0);
        chk("illegal",     32'(illegal),     m_ill ? 1 : 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (resetn) phase = phase + 2'd1;
        alu_zero = (az_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(az_mode);
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic assert_reset();
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        check_all();
    endtask

    task automatic release_reset();
        phase = 2'd0;
        @(posedge clk);
        @(posedge clk);
        #3;
        resetn = 1'b1;
        #1;
        check_all();
    endtask

    task automatic fill_random();
        logic [15:0] w;
        for (int a = 0; a < 256; a++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'hF && $urandom_range(0, 7) != 0) w[15:12] = 4'h0;
            imem[a] = w;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int hcnt;
        for (int a = 0; a < 256; a++) imem[a] = 16'h0000;
        imem[8'h00] = 16'h5105;
        imem[8'h01] = 16'h2000;
        imem[8'h02] = 16'h8010;
        imem[8'h10] = 16'h2000;
        imem[8'h11] = 16'h8010;
        imem[8'h12] = 16'h9020;
        imem[8'h20] = 16'h7003;
        imem[8'h21] = 16'h6203;
        imem[8'h22] = 16'h90FF;
        imem[8'hFF] = 16'h0000;

        model_reset();
        #1;
        check_all();
        chk("reset_pc", 32'(imem_addr), 0);
        chk("reset_halted", 32'(halted), 0);
        release_reset();

        // ADDI r0,5
        ticks(2);
        chk("addi_ex_src_imm", 32'(alu_src_imm), 1);
        chk("addi_ex_imm", 32'(imm), 8'h05);
        tick();
        chk("addi_wb_rf_we", 32'(rf_we), 1);
        chk("addi_wb_rf_waddr", 32'(rf_waddr), 0);
        tick();
        chk("addi_pc", 32'(imem_addr), 1);

        // SUB setting Z, then a taken BEQZ
        az_mode = 1;
        ticks(8);
        chk("beqz_taken_pc", 32'(imem_addr), 8'h10);
        // SUB clearing Z, then a not-taken BEQZ
        az_mode = 0;
        ticks(8);
        chk("beqz_not_taken_pc", 32'(imem_addr), 8'h12);
        az_mode = 2;
        ticks(4);
        chk("jmp20_pc", 32'(imem_addr), 8'h20);

        // ST
        tick();
        chk("st_id_dmem_we", 32'(dmem_we), 0);
        tick();
        chk("st_ex_dmem_we", 32'(dmem_we), 1);
        chk("st_ex_rf_we", 32'(rf_we), 0);
        tick();
        chk("st_wb_dmem_we", 32'(dmem_we), 0);
        chk("st_wb_rf_we", 32'(rf_we), 0);
        tick();
        // LD
        tick();
        chk("ld_id_dmem_re", 32'(dmem_re), 0);
        tick();
        chk("ld_ex_dmem_re", 32'(dmem_re), 1);
        tick();
        chk("ld_wb_dmem_re", 32'(dmem_re), 1);
        chk("ld_wb_rf_we", 32'(rf_we), 1);
        chk("ld_wb_wb_sel", 32'(wb_sel), 1);
        chk("ld_wb_rf_waddr", 32'(rf_waddr), 0);
        tick();
        ticks(4);
        chk("jmpff_pc", 32'(imem_addr), 8'hFF);
        ticks(4);
        chk("pc_wrap", 32'(imem_addr), 8'h00);

        // JMP, illegal opcode, HALT
        assert_reset();
        imem[8'h00] = 16'h9042;
        imem[8'h42] = 16'hB000;
        imem[8'h43] = 16'hF000;
        release_reset();
        ticks(4);
        chk("jmp42_pc", 32'(imem_addr), 8'h42);
        tick();
        chk("illegal_before_id_end", 32'(illegal), 0);
        tick();
        chk("illegal_after_id", 32'(illegal), 1);
        ticks(2);
        chk("illegal_pc_inc", 32'(imem_addr), 8'h43);
        ticks(4);
        chk("halt_halted", 32'(halted), 1);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("halt_pc_frozen", 32'(imem_addr), 8'h43);
            chk("halt_strobes", 32'({rf_we, dmem_re, dmem_we, alu_src_imm}), 0);
        end

        // Reset in the middle of a store
        assert_reset();
        imem[8'h00] = 16'hB000;
        imem[8'h01] = 16'h7003;
        release_reset();
        ticks(6);
        chk("st_before_reset", 32'(dmem_we), 1);
        assert_reset();
        chk("st_abort_dmem_we", 32'(dmem_we), 0);
        release_reset();
        chk("post_reset_pc", 32'(imem_addr), 0);
        chk("post_reset_ir", 32'(imm), 0);
        chk("post_reset_halted", 32'(halted), 0);
        chk("post_reset_illegal", 32'(illegal), 0);

        // Random programs with random Z and occasional asynchronous resets
        assert_reset();
        fill_random();
        release_reset();
        hcnt = 0;
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (m_halt) hcnt++;
            if (hcnt > 10 || $urandom_range(0, 299) == 0) begin
                assert_reset();
                fill_random();
                release_reset();
                hcnt = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
